lsu_unit: RTL and testbench
===========================

Name: lsu_unit

Overview:
- Load/store unit in the MEM stage, directly upstream of the word-organised data RAM.
- Accepts one load or store request at a time from EX/MEM.
- For each request it generates the word address, the 4-bit byte-lane mask and the lane-aligned write data for the data RAM.
- It splits misaligned accesses into two word accesses, then merges, aligns and sign/zero-extends load data for writeback.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width; fixed 4 byte lanes

Ports:
CLK  input  1  clock
rst_n  input  1  reset, synchronous, active-low
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_is_store  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
req_rd  input  5  load destination register
ram_read_op  output  1  data RAM read enable
ram_write_op  output  1  data RAM write enable
ram_addr  output  32  word-aligned address, bits 1:0 = 00
ram_mask  output  4  byte-lane write mask; bit i = data bits 8i+7:8i
ram_wdata  output  32  lane-aligned store data
ram_rdata  input  32  RAM read data, combinational, valid in the same cycle as ram_read_op
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load result; 0 for stores and errors
resp_rd  output  5  echoed req_rd
resp_err  output  1  illegal funct3

Behaviour:
- Reset (rst_n low at a CLK edge):
  - state = IDLE; every output 0 except req_ready = 1.
  - Any in-flight access is abandoned. If a split store already wrote its first word, that write stays and no second write occurs.
- States: IDLE, ACC1, ACC2, RESP.
- Request capture:
  - In IDLE, req_valid = 1 captures all req_* fields at the edge.
  - req_valid is ignored in every other state; no queueing.
- Access size and offset:
  - n = 1/2/4 bytes for B,BU / H,HU / W; o = addr[1:0].
  - Split iff o + n > 4.
  - funct3 011, 110, 111 is illegal: IDLE -> RESP with resp_err = 1 and no RAM access.
- Transitions:
  - IDLE -> ACC1 on accept.
  - ACC1 -> ACC2 if split, else ACC1 -> RESP.
  - ACC2 -> RESP.
  - RESP -> IDLE.
- Latency (accept edge T): aligned resp_valid is high during cycle T+2; split during cycle T+3; error during cycle T+1.
- ACC1 drives:
  - ram_addr = {addr[31:2], 2'b00}.
  - Load: ram_read_op = 1. Store: ram_write_op = 1.
- ACC2 drives:
  - ram_addr = first word address + 4, wrapping modulo 2^32: 0xFFFFFFFC -> 0x00000000.
  - Read/write enable as in ACC1.
- Store lane mapping:
  - Form 64-bit W = zero-extended wdata shifted left by 8*o; active lanes are o..o+n-1 of 8.
  - ACC1: ram_wdata = W[31:0], ram_mask = active lanes 0-3.
  - ACC2: ram_wdata = W[63:32], ram_mask = active lanes 4-7.
  - Outside store access states: ram_mask = 0, ram_wdata = 0.
- Load:
  - ram_rdata is registered at the end of ACC1 (low word) and of ACC2 (high word; 0 if not split).
  - R = {high, low} >> 8*o; take the low n bytes.
  - Sign-extend for B/H, zero-extend for BU/HU/W.
- RAM drive rule: read_op and write_op are never both high; both are 0 in IDLE and RESP. All ram_* outputs are decoded from registered state only.
- RESP: resp_valid = 1, resp_rd = captured rd, resp_rdata per the load rule (0 for a store). Outputs return to 0 the next cycle.

Test Plan:
- Aligned LW: RAM[0x100] = 0x8899AABB, accept LW 0x100 at T -> ACC1 at T+1 with ram_addr 0x100, read_op = 1; resp_valid at T+2 with rdata 0x8899AABB.
- Byte ops:
  - SB 0x000000CD at 0x103 -> single write, mask 1000, wdata 0xCD000000.
  - Then LB 0x103 -> 0xFFFFFFCD; LBU 0x103 -> 0x000000CD.
- Split LH: RAM[0x100] = 0x8899AABB, RAM[0x104] = 0x11223344, LH 0x103 -> two reads at 0x100 and 0x104; resp at T+3 with rdata 0x00004488. LHU 0x102 -> 0x00008899, not split.
- Split SW 0x12345678 at 0x102 -> ACC1 mask 1100, wdata 0x56780000 @0x100; ACC2 mask 0011, wdata 0x00001234 @0x104. A following LW 0x102 reads back 0x12345678.
- Illegal funct3 3'b011 -> resp_valid at T+1, resp_err = 1, rdata 0; read_op/write_op never asserted.
- Reset and boundaries:
  - rst_n low during ACC2 of a split store -> next cycle all outputs 0, req_ready = 1, second word unchanged.
  - req_valid held high throughout -> back-to-back requests each accepted only in IDLE.
  - LW at 0xFFFFFFFE splits to 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/lsu_unit_if.sv
// rtl/lsu_unit_if.sv - request, data RAM and response signals of the load/store unit
interface lsu_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [4:0]        req_rd;
  logic              ram_read_op;
  logic              ram_write_op;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_mask;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic [4:0]        resp_rd;
  logic              resp_err;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd, ram_rdata,
    output req_ready, ram_read_op, ram_write_op, ram_addr, ram_mask, ram_wdata,
    output resp_valid, resp_rdata, resp_rd, resp_err
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd, ram_rdata,
    input  req_ready, ram_read_op, ram_write_op, ram_addr, ram_mask, ram_wdata,
    input  resp_valid, resp_rdata, resp_rd, resp_err
  );
endinterface

// File: rtl/lsu_unit.sv
// rtl/lsu_unit.sv - MEM-stage load/store unit with misaligned split and load extension
module lsu_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic      CLK,
  input  logic      rst_n,
  lsu_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  state_t            state_q, state_d;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] lo_q, hi_q;
  logic [4:0]        rd_q;
  logic              err_q;

  logic              illegal_in;
  logic [1:0]        off;
  logic [7:0]        lanes;
  logic              split;
  logic [63:0]       wshift;
  logic [DATA_W-1:0] rword;
  logic [DATA_W-1:0] ext;
  logic [ADDR_W-1:0] word0;

  assign illegal_in = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
  assign off        = addr_q[1:0];
  assign word0      = {addr_q[ADDR_W-1:2], 2'b00};

  // Byte lanes over the two-word window; anything in lanes 7:4 needs a second access.
  always_comb begin
    lanes = 8'h00;
    case (funct3_q[1:0])
      2'b00:   lanes = 8'h01 << off;
      2'b01:   lanes = 8'h03 << off;
      default: lanes = 8'h0F << off;
    endcase
    split  = |lanes[7:4];
    wshift = {32'b0, wdata_q} << {off, 3'b000};
    rword  = DATA_W'({hi_q, lo_q} >> {off, 3'b000});
    case (funct3_q)
      3'b000:  ext = {{24{rword[7]}}, rword[7:0]};
      3'b001:  ext = {{16{rword[15]}}, rword[15:0]};
      3'b100:  ext = {24'b0, rword[7:0]};
      3'b101:  ext = {16'b0, rword[15:0]};
      default: ext = rword;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    bus.req_ready    = 1'b0;
    bus.ram_read_op  = 1'b0;
    bus.ram_write_op = 1'b0;
    bus.ram_addr     = '0;
    bus.ram_mask     = 4'b0000;
    bus.ram_wdata    = '0;
    bus.resp_valid   = 1'b0;
    bus.resp_rdata   = '0;
    bus.resp_rd      = 5'd0;
    bus.resp_err     = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = illegal_in ? RESP : ACC1;
      end
      ACC1: begin
        bus.ram_addr     = word0;
        bus.ram_read_op  = !is_store_q;
        bus.ram_write_op = is_store_q;
        if (is_store_q) begin
          bus.ram_mask  = lanes[3:0];
          bus.ram_wdata = wshift[31:0];
        end
        state_d = split ? ACC2 : RESP;
      end
      ACC2: begin
        bus.ram_addr     = word0 + ADDR_W'(4);
        bus.ram_read_op  = !is_store_q;
        bus.ram_write_op = is_store_q;
        if (is_store_q) begin
          bus.ram_mask  = lanes[7:4];
          bus.ram_wdata = wshift[63:32];
        end
        state_d = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rd    = rd_q;
        bus.resp_err   = err_q;
        bus.resp_rdata = (is_store_q || err_q) ? '0 : ext;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      rd_q       <= 5'd0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            is_store_q <= bus.req_is_store;
            funct3_q   <= bus.req_funct3;
            addr_q     <= bus.req_addr;
            wdata_q    <= bus.req_wdata;
            rd_q       <= bus.req_rd;
            err_q      <= illegal_in;
            lo_q       <= '0;
            hi_q       <= '0;
          end
        end
        ACC1: if (!is_store_q) lo_q <= bus.ram_rdata;
        ACC2: if (!is_store_q) hi_q <= bus.ram_rdata;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_unit.sv
// tb/tb_lsu_unit.sv - directed bench for lsu_unit against a byte-level memory model
module tb_lsu_unit;
  logic clk;
  logic rst_n;
  lsu_unit_if bus ();

  lsu_unit dut (.CLK(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word RAM seen by the DUT; writes are suppressed while the system is in reset.
  logic [31:0] ram [256] = '{default: 32'h0};
  assign bus.ram_rdata = ram[bus.ram_addr[9:2]];
  always @(posedge clk) begin
    if (rst_n && bus.ram_write_op) begin
      for (int i = 0; i < 4; i++)
        if (bus.ram_mask[i]) ram[bus.ram_addr[9:2]][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
    end
  end

  typedef struct packed {
    logic        rdy;
    logic        rd_op;
    logic        wr_op;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        err;
  } vec_t;

  typedef struct packed {
    vec_t        v;
    logic        has_lit;
    logic [31:0] lit;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] mbytes [logic [31:0]];
  bit run_cmp;
  int n_checks;
  int n_fail;

  function automatic vec_t idle_vec();
    vec_t v;
    v = '0;
    v.rdy = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input int n, input logic [2:0] f3);
    logic [31:0] v;
    logic [31:0] a;
    v = '0;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      v[8*k +: 8] = mbytes.exists(a) ? mbytes[a] : 8'h00;
    end
    if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // Expected per-cycle outputs derived byte by byte from the access rules.
  task automatic model_req(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd,
                           input bit has_lit, input logic [31:0] lit, input bit trunc);
    exp_t e1, e2, er;
    int n, o, lane;
    logic [31:0] a0, a;
    bit split;
    e1 = '0; e2 = '0; er = '0;
    er.v.rv = 1'b1;
    er.v.rd = rd;
    er.has_lit = has_lit;
    er.lit = lit;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) begin
      er.v.err = 1'b1;
      exp_q.push_back(er);
      return;
    end
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    o = int'(addr[1:0]);
    a0 = addr & 32'hFFFF_FFFC;
    split = (o + n) > 4;
    e1.v.rd_op = !st; e1.v.wr_op = st; e1.v.addr = a0;
    e2.v.rd_op = !st; e2.v.wr_op = st; e2.v.addr = a0 + 32'd4;
    if (st) begin
      for (int k = 0; k < n; k++) begin
        lane = o + k;
        if (lane < 4) begin
          e1.v.mask[lane] = 1'b1;
          e1.v.wdata[8*lane +: 8] = wd[8*k +: 8];
        end else begin
          e2.v.mask[lane-4] = 1'b1;
          e2.v.wdata[8*(lane-4) +: 8] = wd[8*k +: 8];
        end
      end
    end else begin
      er.v.rdata = model_load(addr, n, f3);
    end
    exp_q.push_back(e1);
    if (split) exp_q.push_back(e2);
    if (!trunc) exp_q.push_back(er);
    if (st) begin
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        if (!trunc || (o + k) < 4) mbytes[a] = wd[8*k +: 8];
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    vec_t act;
    if (run_cmp) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin
        e = '0;
        e.v = idle_vec();
      end
      act = {bus.req_ready, bus.ram_read_op, bus.ram_write_op, bus.ram_addr, bus.ram_mask,
             bus.ram_wdata, bus.resp_valid, bus.resp_rdata, bus.resp_rd, bus.resp_err};
      n_checks++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t got %h want %h", $time, act, e.v);
      end
      if (e.has_lit) begin
        n_checks++;
        if (bus.resp_rdata !== e.lit) begin
          n_fail++;
          $display("FAIL resp_literal t=%0t got %h want %h", $time, bus.resp_rdata, e.lit);
        end
      end
    end
  end

  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input bit hold,
                        input bit has_lit, input logic [31:0] lit, input bit trunc);
    int waited;
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_rd       = rd;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      waited++;
      if (waited > 20) begin
        $display("FAIL accept_timeout addr %h got ready 0 want 1", addr);
        $fatal(1, "request never accepted");
      end
    end
    @(posedge clk);
    #1;
    model_req(st, f3, addr, wd, rd, has_lit, lit, trunc);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  initial begin
    int waited;
    rst_n = 1'b0;
    run_cmp = 1'b0;
    n_checks = 0;
    n_fail = 0;
    bus.req_valid = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_rd = 5'd0;
    repeat (2) @(posedge clk);
    #1 run_cmp = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Preload back to back with req_valid held high.
    do_req(1, 3'b010, 32'h100, 32'h8899AABB, 5'd0, 1, 0, 0, 0);
    do_req(1, 3'b010, 32'h104, 32'h11223344, 5'd0, 0, 0, 0, 0);
    do_req(0, 3'b010, 32'h100, 0, 5'd1, 0, 1, 32'h8899AABB, 0);

    do_req(1, 3'b000, 32'h103, 32'h000000CD, 5'd0, 0, 0, 0, 0);
    do_req(0, 3'b000, 32'h103, 0, 5'd2, 0, 1, 32'hFFFFFFCD, 0);
    do_req(0, 3'b100, 32'h103, 0, 5'd3, 0, 1, 32'h000000CD, 0);

    do_req(1, 3'b010, 32'h100, 32'h8899AABB, 5'd0, 0, 0, 0, 0);
    do_req(0, 3'b001, 32'h103, 0, 5'd4, 0, 1, 32'h00004488, 0);
    do_req(0, 3'b101, 32'h102, 0, 5'd5, 0, 1, 32'h00008899, 0);
    do_req(0, 3'b001, 32'h101, 0, 5'd6, 0, 1, 32'hFFFF99AA, 0);

    do_req(1, 3'b010, 32'h102, 32'h12345678, 5'd0, 0, 0, 0, 0);
    do_req(0, 3'b010, 32'h102, 0, 5'd7, 0, 1, 32'h12345678, 0);

    do_req(0, 3'b011, 32'h100, 0, 5'd8, 0, 1, 32'h0, 0);
    do_req(1, 3'b110, 32'h104, 32'hFFFFFFFF, 5'd9, 0, 1, 32'h0, 0);
    do_req(0, 3'b111, 32'h103, 0, 5'd10, 0, 1, 32'h0, 0);

    // Back-to-back mix with valid held, including a split halfword store.
    do_req(1, 3'b001, 32'h107, 32'h0000BEEF, 5'd0, 1, 0, 0, 0);
    do_req(0, 3'b101, 32'h107, 0, 5'd11, 1, 1, 32'h0000BEEF, 0);
    do_req(0, 3'b011, 32'h0, 0, 5'd12, 1, 1, 32'h0, 0);
    do_req(0, 3'b000, 32'h106, 0, 5'd13, 0, 1, 32'h00000022, 0);

    do_req(1, 3'b010, 32'hFFFFFFFC, 32'hA1B2C3D4, 5'd0, 0, 0, 0, 0);
    do_req(1, 3'b010, 32'h0, 32'h55667788, 5'd0, 0, 0, 0, 0);
    do_req(0, 3'b010, 32'hFFFFFFFE, 0, 5'd14, 0, 1, 32'h7788A1B2, 0);

    // Reset lands at the edge that ends ACC2 of a split store.
    do_req(1, 3'b010, 32'h100, 32'h8899AABB, 5'd0, 0, 0, 0, 0);
    do_req(1, 3'b010, 32'h104, 32'h11223344, 5'd0, 0, 0, 0, 0);
    do_req(1, 3'b010, 32'h101, 32'hDEADBEEF, 5'd0, 0, 0, 0, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_req(0, 3'b010, 32'h100, 0, 5'd15, 0, 1, 32'hADBEEFBB, 0);
    do_req(0, 3'b010, 32'h104, 0, 5'd16, 0, 1, 32'h11223344, 0);

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
